// File: rtl/snake_body_engine.sv
// Snake game-state engine: body ring buffer plus grid occupancy bitmap, a
// per-step move FSM (wrap or wall edges, food growth, self-collision) and a cell query port.
module snake_body_engine #(
    parameter int unsigned GRID_W   = 16,
    parameter int unsigned GRID_H   = 16,
    parameter int unsigned XW       = 4,
    parameter int unsigned YW       = 4,
    parameter int unsigned MAX_LEN  = 64,
    parameter int unsigned LW       = 7,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned WRAP     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          step,
    input  logic [1:0]    dir,
    input  logic          food_valid,
    input  logic [XW-1:0] food_x,
    input  logic [YW-1:0] food_y,
    output logic          busy,
    output logic          step_done,
    output logic          ate,
    output logic          game_over,
    output logic [LW-1:0] length,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    input  logic [XW-1:0] q_x,
    input  logic [YW-1:0] q_y,
    output logic          q_occ,
    output logic          q_head
);
    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned PW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned MID_Y = GRID_H / 2;

    typedef enum logic [2:0] {IDLE, CALC, TAIL, CHECK, COMMIT, OVER} state_t;

    state_t          state_q, state_d;
    logic [CELLS-1:0] occ_q, occ_d;
    logic [XW-1:0]   ring_x_q [MAX_LEN];
    logic [XW-1:0]   ring_x_d [MAX_LEN];
    logic [YW-1:0]   ring_y_q [MAX_LEN];
    logic [YW-1:0]   ring_y_d [MAX_LEN];
    logic [PW-1:0]   head_ptr_q, head_ptr_d, tail_ptr_q, tail_ptr_d, wr_ptr;
    logic [LW-1:0]   len_q, len_d;
    logic [1:0]      last_dir_q, last_dir_d, mv_dir_q, mv_dir_d;
    logic            food_v_q, food_v_d, eat_q, eat_d;
    logic [XW-1:0]   food_x_q, food_x_d, hx_q, hx_d, nx_q, nx_d, nxt_x;
    logic [YW-1:0]   food_y_q, food_y_d, hy_q, hy_d, ny_q, ny_d, nxt_y;
    logic            busy_q, busy_d, done_q, done_d, ate_q, ate_d, over_q, over_d;
    logic            q_occ_q, q_occ_d, q_head_q, q_head_d, q_in, off_grid;

    function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return IW'(32'(y) * GRID_W + 32'(x));
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == MAX_LEN - 1) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [CELLS-1:0] init_occ();
        logic [CELLS-1:0] o;
        o = '0;
        for (int unsigned i = 0; i < INIT_LEN; i++) o[cell_idx(XW'(i), YW'(MID_Y))] = 1'b1;
        return o;
    endfunction

    // Candidate head one cell along the latched direction; off_grid only matters in wall mode
    always_comb begin
        nxt_x    = hx_q;
        nxt_y    = hy_q;
        off_grid = 1'b0;
        case (mv_dir_q)
            2'b00: begin
                if (32'(hx_q) == GRID_W - 1) begin
                    nxt_x    = '0;
                    off_grid = 1'b1;
                end else nxt_x = hx_q + XW'(1);
            end
            2'b01: begin
                if (hx_q == '0) begin
                    nxt_x    = XW'(GRID_W - 1);
                    off_grid = 1'b1;
                end else nxt_x = hx_q - XW'(1);
            end
            2'b10: begin
                if (32'(hy_q) == GRID_H - 1) begin
                    nxt_y    = '0;
                    off_grid = 1'b1;
                end else nxt_y = hy_q + YW'(1);
            end
            default: begin
                if (hy_q == '0) begin
                    nxt_y    = YW'(GRID_H - 1);
                    off_grid = 1'b1;
                end else nxt_y = hy_q - YW'(1);
            end
        endcase
        if (WRAP != 0) off_grid = 1'b0;
    end

    // Move FSM, body storage updates and query answer
    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        ring_x_d   = ring_x_q;
        ring_y_d   = ring_y_q;
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        wr_ptr     = ptr_inc(head_ptr_q);
        len_d      = len_q;
        last_dir_d = last_dir_q;
        mv_dir_d   = mv_dir_q;
        food_v_d   = food_v_q;
        food_x_d   = food_x_q;
        food_y_d   = food_y_q;
        hx_d       = hx_q;
        hy_d       = hy_q;
        nx_d       = nx_q;
        ny_d       = ny_q;
        eat_d      = eat_q;
        done_d     = 1'b0;
        ate_d      = 1'b0;
        q_in       = (32'(q_x) < GRID_W) && (32'(q_y) < GRID_H);
        q_occ_d    = 1'b0;
        q_head_d   = 1'b0;
        if (q_in) begin
            q_occ_d  = occ_q[cell_idx(q_x, q_y)];
            q_head_d = (q_x == hx_q) && (q_y == hy_q);
        end

        if (restart) begin
            state_d    = IDLE;
            occ_d      = init_occ();
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                ring_x_d[i] = (i < INIT_LEN) ? XW'(i) : '0;
                ring_y_d[i] = YW'(MID_Y);
            end
            head_ptr_d = PW'(INIT_LEN - 1);
            tail_ptr_d = '0;
            len_d      = LW'(INIT_LEN);
            last_dir_d = 2'b00;
            mv_dir_d   = 2'b00;
            hx_d       = XW'(INIT_LEN - 1);
            hy_d       = YW'(MID_Y);
            eat_d      = 1'b0;
            q_occ_d    = 1'b0;
            q_head_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (step) begin
                        // A direct reversal would bite the neck, so keep going straight
                        if ((dir[1] == last_dir_q[1]) && (dir[0] != last_dir_q[0]) && (len_q > LW'(1))) begin
                            mv_dir_d = last_dir_q;
                        end else begin
                            mv_dir_d   = dir;
                            last_dir_d = dir;
                        end
                        food_v_d = food_valid;
                        food_x_d = food_x;
                        food_y_d = food_y;
                        state_d  = CALC;
                    end
                end
                CALC: begin
                    nx_d    = nxt_x;
                    ny_d    = nxt_y;
                    eat_d   = food_v_q && (nxt_x == food_x_q) && (nxt_y == food_y_q);
                    state_d = off_grid ? OVER : TAIL;
                end
                TAIL: begin
                    if (!eat_q || (len_q == LW'(MAX_LEN))) begin
                        occ_d[cell_idx(ring_x_q[tail_ptr_q], ring_y_q[tail_ptr_q])] = 1'b0;
                        tail_ptr_d = ptr_inc(tail_ptr_q);
                    end
                    state_d = CHECK;
                end
                CHECK: state_d = occ_q[cell_idx(nx_q, ny_q)] ? OVER : COMMIT;
                COMMIT: begin
                    occ_d[cell_idx(nx_q, ny_q)] = 1'b1;
                    ring_x_d[wr_ptr] = nx_q;
                    ring_y_d[wr_ptr] = ny_q;
                    head_ptr_d = wr_ptr;
                    hx_d       = nx_q;
                    hy_d       = ny_q;
                    if (eat_q && (len_q != LW'(MAX_LEN))) len_d = len_q + LW'(1);
                    done_d  = 1'b1;
                    ate_d   = eat_q;
                    state_d = IDLE;
                end
                OVER:    state_d = OVER;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == CALC) || (state_d == TAIL) || (state_d == CHECK) || (state_d == COMMIT);
        over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            occ_q      <= init_occ();
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                ring_x_q[i] <= (i < INIT_LEN) ? XW'(i) : '0;
                ring_y_q[i] <= YW'(MID_Y);
            end
            head_ptr_q <= PW'(INIT_LEN - 1);
            tail_ptr_q <= '0;
            len_q      <= LW'(INIT_LEN);
            last_dir_q <= 2'b00;
            mv_dir_q   <= 2'b00;
            food_v_q   <= 1'b0;
            food_x_q   <= '0;
            food_y_q   <= '0;
            hx_q       <= XW'(INIT_LEN - 1);
            hy_q       <= YW'(MID_Y);
            nx_q       <= '0;
            ny_q       <= '0;
            eat_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ate_q      <= 1'b0;
            over_q     <= 1'b0;
            q_occ_q    <= 1'b0;
            q_head_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            ring_x_q   <= ring_x_d;
            ring_y_q   <= ring_y_d;
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            len_q      <= len_d;
            last_dir_q <= last_dir_d;
            mv_dir_q   <= mv_dir_d;
            food_v_q   <= food_v_d;
            food_x_q   <= food_x_d;
            food_y_q   <= food_y_d;
            hx_q       <= hx_d;
            hy_q       <= hy_d;
            nx_q       <= nx_d;
            ny_q       <= ny_d;
            eat_q      <= eat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ate_q      <= ate_d;
            over_q     <= over_d;
            q_occ_q    <= q_occ_d;
            q_head_q   <= q_head_d;
        end
    end

    assign busy      = busy_q;
    assign step_done = done_q;
    assign ate       = ate_q;
    assign game_over = over_q;
    assign length    = len_q;
    assign head_x    = hx_q;
    assign head_y    = hy_q;
    assign q_occ     = q_occ_q;
    assign q_head    = q_head_q;
endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: a queue-based game model checked every cycle against a
// wrapping 16x16 instance, plus directed wall-mode checks on a 12x10 instance.
module tb_snake_body_engine;
    localparam int unsigned W = 16, H = 16, ML = 8, LWD = 4, IL = 3;
    localparam int unsigned W0 = 12, H0 = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    initial forever #5 clk = ~clk;

    logic           restart, step, food_valid, busy, step_done, ate, game_over, q_occ, q_head;
    logic [1:0]     dir;
    logic [3:0]     food_x, food_y, q_x, q_y, head_x, head_y;
    logic [LWD-1:0] length;

    logic           restart0, step0, food_valid0, busy0, step_done0, ate0, game_over0, q_occ0, q_head0;
    logic [1:0]     dir0;
    logic [3:0]     food_x0, food_y0, q_x0, q_y0, head_x0, head_y0;
    logic [LWD-1:0] length0;

    snake_body_engine #(.GRID_W(W), .GRID_H(H), .XW(4), .YW(4), .MAX_LEN(ML), .LW(LWD),
                        .INIT_LEN(IL), .WRAP(1)) dut (
        .clk(clk), .rst(rst), .restart(restart), .step(step), .dir(dir),
        .food_valid(food_valid), .food_x(food_x), .food_y(food_y),
        .busy(busy), .step_done(step_done), .ate(ate), .game_over(game_over),
        .length(length), .head_x(head_x), .head_y(head_y),
        .q_x(q_x), .q_y(q_y), .q_occ(q_occ), .q_head(q_head));

    snake_body_engine #(.GRID_W(W0), .GRID_H(H0), .XW(4), .YW(4), .MAX_LEN(ML), .LW(LWD),
                        .INIT_LEN(IL), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .restart(restart0), .step(step0), .dir(dir0),
        .food_valid(food_valid0), .food_x(food_x0), .food_y(food_y0),
        .busy(busy0), .step_done(step_done0), .ate(ate0), .game_over(game_over0),
        .length(length0), .head_x(head_x0), .head_y(head_y0),
        .q_x(q_x0), .q_y(q_y0), .q_occ(q_occ0), .q_head(q_head0));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: body is a queue of cells, tail at front, head at back
    int m_body[$];
    int m_len, m_hx, m_hy, m_last, m_age, m_nx, m_ny;
    bit m_over, m_pend, m_eat, m_drop, m_collide;
    bit e_sd, e_ate, e_qo, e_qh;

    function automatic int key(input int x, input int y);
        return x * 1000 + y;
    endfunction

    function automatic bit occupied(input int x, input int y);
        foreach (m_body[i]) if (m_body[i] == key(x, y)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int ddx(input int d);
        case (d)
            0: return 1;
            1: return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int ddy(input int d);
        case (d)
            2: return 1;
            3: return -1;
            default: return 0;
        endcase
    endfunction

    task automatic model_init();
        m_body.delete();
        for (int i = 0; i < int'(IL); i++) m_body.push_back(key(i, int'(H / 2)));
        m_len = IL; m_hx = IL - 1; m_hy = H / 2; m_last = 0;
        m_over = 0; m_pend = 0; m_age = 0;
        e_sd = 0; e_ate = 0; e_qo = 0; e_qh = 0;
    endtask

    task automatic model_accept();
        int d;
        d = int'(dir);
        if (ddx(d) + ddx(m_last) == 0 && ddy(d) + ddy(m_last) == 0 && m_len > 1) d = m_last;
        else m_last = d;
        m_nx = (m_hx + ddx(d) + int'(W)) % int'(W);
        m_ny = (m_hy + ddy(d) + int'(H)) % int'(H);
        m_eat = food_valid && int'(food_x) == m_nx && int'(food_y) == m_ny;
        m_drop = !m_eat || m_len == int'(ML);
        m_collide = occupied(m_nx, m_ny) && !(m_drop && m_body[0] == key(m_nx, m_ny));
        m_pend = 1; m_age = 0;
    endtask

    // Model advance: one call per rising edge, effects visible as the timeline dictates
    initial begin
        model_init();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst || restart) model_init();
            else begin
                e_qo = occupied(int'(q_x), int'(q_y));
                e_qh = int'(q_x) == m_hx && int'(q_y) == m_hy;
                e_sd = 0; e_ate = 0;
                if (m_pend) begin
                    m_age++;
                    if (m_age == 2 && m_drop) void'(m_body.pop_front());
                    else if (m_age == 3 && m_collide) begin
                        m_over = 1; m_pend = 0;
                    end else if (m_age == 4) begin
                        m_body.push_back(key(m_nx, m_ny));
                        m_hx = m_nx; m_hy = m_ny;
                        if (m_eat && m_len < int'(ML)) m_len++;
                        e_sd = 1; e_ate = m_eat; m_pend = 0;
                    end
                end else if (step && !m_over) model_accept();
            end
        end
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("busy", int'(busy), int'(m_pend));
            chk("step_done", int'(step_done), int'(e_sd));
            chk("ate", int'(ate), int'(e_ate));
            chk("game_over", int'(game_over), int'(m_over));
            chk("length", int'(length), m_len);
            chk("head_x", int'(head_x), m_hx);
            chk("head_y", int'(head_y), m_hy);
            chk("q_occ", int'(q_occ), int'(e_qo));
            chk("q_head", int'(q_head), int'(e_qh));
        end
    end

    task automatic step1(input logic [1:0] d, input logic fv, input int fx, input int fy,
                         output int lat, output int nb, output int a);
        step = 1'b1; dir = d; food_valid = fv; food_x = 4'(fx); food_y = 4'(fy);
        lat = -1; nb = 0; a = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            step = 1'b0; food_valid = 1'b0;
            if (busy) nb++;
            if (step_done || game_over) begin
                lat = k; a = int'(ate);
                break;
            end
        end
    endtask

    task automatic query1(input int x, input int y, output int o, output int h);
        q_x = 4'(x); q_y = 4'(y);
        @(negedge clk);
        o = int'(q_occ); h = int'(q_head);
    endtask

    task automatic query0(input int x, input int y, output int o, output int h);
        q_x0 = 4'(x); q_y0 = 4'(y);
        @(negedge clk);
        o = int'(q_occ0); h = int'(q_head0);
    endtask

    task automatic step0_x(output int lat, output int nb, output int sd, output int a);
        step0 = 1'b1; dir0 = 2'b00;
        lat = -1; nb = 0; sd = 0; a = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            step0 = 1'b0;
            if (busy0) nb++;
            if (step_done0) sd = 1;
            if (ate0) a = 1;
            if (step_done0 || game_over0) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, nb, a, o, h, sd, found, over_cnt;
        restart = 0; step = 0; dir = 0; food_valid = 0; food_x = 0; food_y = 0; q_x = 0; q_y = 0;
        restart0 = 0; step0 = 0; dir0 = 0; food_valid0 = 0; food_x0 = 0; food_y0 = 0; q_x0 = 0; q_y0 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_len", int'(length), 3);
        chk("rst_head", int'(head_x) * 100 + int'(head_y), 208);
        chk("rst_busy_over", int'(busy) + int'(game_over) + int'(step_done), 0);
        for (int x = 0; x < 4; x++) begin
            query1(x, 8, o, h);
            chk("rst_q_occ", o, (x < 3) ? 1 : 0);
            chk("rst_q_head", h, (x == 2) ? 1 : 0);
        end

        // Timing of a plain move, then run into the right edge and wrap
        step1(2'b00, 0, 0, 0, lat, nb, a);
        chk("move_latency", lat, 5);
        chk("move_busy_cycles", nb, 4);
        chk("move_head_x", int'(head_x), 3);
        for (int i = 0; i < 12; i++) step1(2'b00, 0, 0, 0, lat, nb, a);
        chk("edge_head_x", int'(head_x), 15);
        step1(2'b00, 0, 0, 0, lat, nb, a);
        chk("wrap_head", int'(head_x) * 100 + int'(head_y), 8);
        chk("wrap_over", int'(game_over), 0);

        // Eat, then a plain move
        step1(2'b00, 1, 1, 8, lat, nb, a);
        chk("eat_ate", a, 1);
        chk("eat_len", int'(length), 4);
        query1(14, 8, o, h);
        chk("eat_tail_kept", o, 1);
        step1(2'b00, 0, 0, 0, lat, nb, a);
        chk("plain_ate", a, 0);
        chk("plain_len", int'(length), 4);
        query1(14, 8, o, h);
        chk("plain_tail_cleared", o, 0);

        // Reversal request plus a step pulse while busy
        step = 1; dir = 2'b01;
        @(negedge clk); step = 0;
        @(negedge clk); step = 1; dir = 2'b10;
        @(negedge clk); step = 0;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (step_done) begin
                found = 1;
                break;
            end
        end
        chk("rev_done", found, 1);
        repeat (6) @(negedge clk);
        chk("rev_head", int'(head_x) * 100 + int'(head_y), 308);
        chk("rev_busy", int'(busy), 0);

        // Grow to five and curl back into the body
        step1(2'b00, 1, 4, 8, lat, nb, a);
        chk("grow5_len", int'(length), 5);
        step1(2'b10, 0, 0, 0, lat, nb, a);
        step1(2'b01, 0, 0, 0, lat, nb, a);
        step1(2'b11, 0, 0, 0, lat, nb, a);
        chk("coll_latency", lat, 4);
        chk("coll_over", int'(game_over), 1);
        chk("coll_head", int'(head_x) * 100 + int'(head_y), 309);
        chk("coll_len", int'(length), 5);
        query1(2, 8, o, h);
        chk("coll_tail_gone", o, 0);
        step = 1; dir = 2'b00;
        @(negedge clk); step = 0;
        repeat (6) @(negedge clk);
        chk("over_frozen", int'(head_x) * 100 + int'(head_y) + 10000 * int'(busy), 309);
        restart = 1;
        @(negedge clk); restart = 0;
        chk("restart_state", int'(length) * 10000 + int'(head_x) * 100 + int'(head_y), 30208);
        chk("restart_over", int'(game_over) + int'(busy), 0);

        // Wall mode on the 12x10 grid
        for (int i = 0; i < 9; i++) step0_x(lat, nb, sd, a);
        chk("w0_head", int'(head_x0) * 100 + int'(head_y0), 1105);
        chk("w0_ate", a, 0);
        step0_x(lat, nb, sd, a);
        chk("w0_leave_latency", lat, 2);
        chk("w0_leave_no_done", sd, 0);
        chk("w0_leave_state", int'(game_over0) * 10 + int'(busy0), 10);
        chk("w0_leave_head", int'(length0) * 10000 + int'(head_x0) * 100 + int'(head_y0), 31105);
        query0(12, 5, o, h);
        chk("w0_q_x_out", o + h, 0);
        query0(3, 10, o, h);
        chk("w0_q_y_out", o + h, 0);
        query0(11, 5, o, h);
        chk("w0_q_head", o * 10 + h, 11);
        restart0 = 1;
        @(negedge clk); restart0 = 0;
        chk("w0_restart", int'(game_over0) * 10000 + int'(head_x0) * 100 + int'(head_y0), 205);
        step0 = 1; dir0 = 2'b00;
        @(negedge clk); step0 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("w0_check_busy", int'(busy0), 1);
        restart0 = 1;
        @(negedge clk); restart0 = 0;
        chk("w0_abort_busy", int'(busy0) + int'(step_done0) + int'(game_over0), 0);
        chk("w0_abort_len", int'(length0), 3);
        @(negedge clk);
        chk("w0_abort_no_done", int'(step_done0) * 100 + int'(head_x0), 2);

        // Random play against the model
        over_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            step = ($urandom_range(0, 2) == 0);
            dir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                food_valid = 1'b1;
                food_x = 4'((m_hx + ddx(int'(dir)) + int'(W)) % int'(W));
                food_y = 4'((m_hy + ddy(int'(dir)) + int'(H)) % int'(H));
            end else begin
                food_valid = ($urandom_range(0, 3) == 0);
                food_x = 4'($urandom_range(0, 15));
                food_y = 4'($urandom_range(0, 15));
            end
            q_x = 4'($urandom_range(0, 15));
            q_y = 4'($urandom_range(0, 15));
            over_cnt = m_over ? over_cnt + 1 : 0;
            restart = ($urandom_range(0, 399) == 0) || (over_cnt > 4);
            @(negedge clk);
        end
        restart = 0; step = 0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
